// File: rtl/mag_cmp_serial.sv
// Bit-serial MSB-first magnitude comparator, unsigned or two's-complement per operation.
// Latches a/b on an accepted start, scans one bit per clock, pulses done with eq/lt/gt.
module mag_cmp_serial #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx;
    logic             found, first_gt;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic             bit_a, bit_b, diff, msb, last;
    logic             diff_gt, dec_found, dec_gt;

    assign a_sh  = a_q >> idx;
    assign b_sh  = b_q >> idx;
    assign bit_a = a_sh[0];
    assign bit_b = b_sh[0];
    assign diff  = bit_a ^ bit_b;
    assign msb   = (idx == IW'(WIDTH - 1));
    assign last  = (idx == '0);

    // A set sign bit makes A negative, so in signed mode the MSB decision flips.
    assign diff_gt   = (sgn_q && msb) ? bit_b : bit_a;
    assign dec_found = found | diff;
    assign dec_gt    = found ? first_gt : diff_gt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            idx      <= '0;
            found    <= 1'b0;
            first_gt <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            gt       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        sgn_q    <= signed_mode;
                        idx      <= IW'(WIDTH - 1);
                        found    <= 1'b0;
                        first_gt <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if ((EARLY_EXIT && diff) || last) begin
                        eq    <= ~dec_found;
                        gt    <= dec_found & dec_gt;
                        lt    <= dec_found & ~dec_gt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Only the first difference counts; later ones leave the record alone.
                        idx      <= idx - 1'b1;
                        found    <= dec_found;
                        first_gt <= dec_gt;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mag_cmp_serial.sv
// Randomized/directed bench for mag_cmp_serial: three builds (W8 early-exit, W8 fixed, W1)
// checked against an arithmetic reference for flags, latency and busy duration.
module tb_mag_cmp_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0;
    logic [7:0] a_r = '0, b_r = '0;
    logic       sm_r = 1'b0;
    logic [2:0] busy, done, eq, lt, gt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mag_cmp_serial #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .start(start[0]), .a(a_r), .b(b_r), .signed_mode(sm_r),
        .busy(busy[0]), .done(done[0]), .eq(eq[0]), .lt(lt[0]), .gt(gt[0]));
    mag_cmp_serial #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_fix (
        .clk(clk), .rst(rst), .start(start[1]), .a(a_r), .b(b_r), .signed_mode(sm_r),
        .busy(busy[1]), .done(done[1]), .eq(eq[1]), .lt(lt[1]), .gt(gt[1]));
    mag_cmp_serial #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a_r[0:0]), .b(b_r[0:0]), .signed_mode(sm_r),
        .busy(busy[2]), .done(done[2]), .eq(eq[2]), .lt(lt[2]), .gt(gt[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // d: 0 = W8 early exit, 1 = W8 fixed latency, 2 = W1.
    // poke: re-pulse start with other operands mid-compare and in the done cycle.
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input logic sm, input bit poke);
        int w, sa, sb, first, k, exp_lat, lat, bsy;
        bit seen;
        logic [2:0] exp_f;
        w = (d == 2) ? 1 : 8;
        if (w == 1) begin
            sa = sm ? (av[0] ? -1 : 0) : int'(av[0]);
            sb = sm ? (bv[0] ? -1 : 0) : int'(bv[0]);
        end else begin
            sa = sm ? int'($signed(av)) : int'(av);
            sb = sm ? int'($signed(bv)) : int'(bv);
        end
        exp_f = {sa == sb, sa < sb, sa > sb};
        first = -1;
        for (int i = w - 1; i >= 0; i--)
            if (av[i] != bv[i]) begin
                first = i;
                break;
            end
        k = (d == 1 || first < 0) ? w : w - first;
        exp_lat = k + 1;

        @(negedge clk);
        a_r = av; b_r = bv; sm_r = sm; start[d] = 1'b1;
        lat = 0; bsy = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            start[d] = 1'b0;
            lat++;
            if (done[d]) seen = 1;
            else begin
                if (busy[d]) bsy++;
                if (poke && lat == 2) begin
                    a_r = 8'h00; b_r = 8'h01; sm_r = 1'b0; start[d] = 1'b1;
                end
            end
        end
        chk($sformatf("d%0d_done_seen", d), 32'(seen), 32'd1);
        chk($sformatf("d%0d_latency a=%02h b=%02h s=%0d", d, av, bv, sm), 32'(lat), 32'(exp_lat));
        chk($sformatf("d%0d_busy_cycles", d), 32'(bsy), 32'(k));
        chk($sformatf("d%0d_flags a=%02h b=%02h s=%0d", d, av, bv, sm),
            32'({eq[d], lt[d], gt[d]}), 32'(exp_f));
        if (poke) begin
            a_r = 8'h00; b_r = 8'h01; sm_r = 1'b0; start[d] = 1'b1;
        end
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk($sformatf("d%0d_after_done", d), 32'({busy[d], done[d], eq[d], lt[d], gt[d]}),
            32'({2'b00, exp_f}));
    endtask

    initial begin
        int seen_done;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({busy, done, eq, lt, gt}), 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op(0, 8'h5A, 8'h5A, 1'b0, 1'b0);
        run_op(0, 8'h80, 8'h7F, 1'b0, 1'b0);
        run_op(0, 8'h80, 8'h7F, 1'b1, 1'b0);
        run_op(1, 8'hFE, 8'hFF, 1'b1, 1'b0);
        run_op(1, 8'h81, 8'h00, 1'b1, 1'b0);
        run_op(0, 8'hC3, 8'hC3, 1'b0, 1'b1);
        run_op(0, 8'h00, 8'h01, 1'b0, 1'b0);
        run_op(1, 8'h44, 8'h40, 1'b0, 1'b1);

        // Reset on the third CMP cycle aborts with no done pulse
        @(negedge clk);
        a_r = 8'h00; b_r = 8'h00; sm_r = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_abort_outputs", 32'({busy[0], done[0], eq[0], lt[0], gt[0]}), 32'd0);
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done[0]) seen_done++;
        end
        chk("rst_abort_no_done", 32'(seen_done), 32'd0);
        run_op(0, 8'h12, 8'h34, 1'b0, 1'b0);

        // WIDTH=1, every pair in both modes
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 4; p++)
                run_op(2, 8'(p >> 1), 8'(p & 1), m[0], 1'b0);

        // Random; operands sometimes share a prefix to move the first difference down
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op(i % 3, ra, rb, 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
